// File: rtl/par_to_ser_pkg.sv
`default_nettype none
// ============================================================================
// Module   : par_to_ser_pkg
// Brief    : Shared FSM encodings and preamble constant for the framed
//            parallel-to-serial transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package par_to_ser_pkg;

    // Framer FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2,
        ST_PAR  = 2'd3
    } state_t;

    // Alternating 1010... pattern; the default preamble is its top PREAMBLE
    // bits, so it always starts with a 1 (6'b101010 for a 6-bit preamble).
    localparam logic [63:0] c_preamble_pat = {32{2'b10}};

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO with occupancy count. A push into an empty FIFO
//            that coincides with a pop passes straight through to the output.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [DATA_W-1:0]        i_data,
    output logic [DATA_W-1:0]        o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int                  c_addr_w = $clog2(DEPTH);
    localparam int                  c_cnt_w  = c_addr_w + 1;
    localparam logic [c_addr_w:0]   c_full   = c_cnt_w'(DEPTH);

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_addr_w:0]   r_count;

    logic w_empty;
    logic w_full;
    logic w_bypass;
    logic w_wr;
    logic w_rd;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_full);
    // Push and pop on an empty FIFO: the word is consumed without storage.
    assign w_bypass = w_empty & i_push & i_pop;
    // When full, a same-edge pop frees the slot being written.
    assign w_wr     = i_push & (~w_full | i_pop) & ~w_bypass;
    assign w_rd     = i_pop & ~w_empty;

    assign o_data   = w_empty ? i_data : r_mem[r_rd_ptr];
    assign o_full   = w_full;
    assign o_empty  = w_empty;
    assign o_count  = r_count;

    // Storage array; contents are don't-care while the pointers say empty
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/framed_par_to_ser.sv
`default_nettype none
// ============================================================================
// Module   : framed_par_to_ser
// Brief    : Buffered parallel-to-serial framer. Emits a preamble followed by
//            every buffered word back-to-back, with optional per-word parity.
// Revision : 1.0 - initial release
// ============================================================================
module framed_par_to_ser
    import par_to_ser_pkg::*;
#(
    parameter int                  DATA_W       = 8,
    parameter int                  DEPTH        = 8,
    parameter int                  PREAMBLE     = 6,
    parameter logic [PREAMBLE-1:0] PREAMBLE_PAT = c_preamble_pat[63 -: PREAMBLE],
    parameter bit                  MSB_FIRST    = 1'b1,
    parameter bit                  PARITY_EN    = 1'b0,
    parameter bit                  PARITY_ODD   = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] prl_data_i,
    output logic              ser_data_o,
    output logic              en_o,
    output logic              busy_o,
    output logic              full_o,
    output logic              ovf_o
);

    localparam int c_max_len = (PREAMBLE > DATA_W) ? PREAMBLE : DATA_W;
    localparam int c_cnt_w   = $clog2(c_max_len) + 1;

    state_t              r_state;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [DATA_W-1:0]   r_shift;
    logic                r_par;
    logic                r_ser;
    logic                r_en;
    logic                r_ovf;

    logic [DATA_W-1:0]       w_fifo_data;
    logic                    w_full;
    logic                    w_empty;
    logic [$clog2(DEPTH):0]  w_count;
    logic                    w_pre_done;
    logic                    w_word_done;
    logic                    w_avail;
    logic                    w_pop;
    logic                    w_load_ser;
    logic [DATA_W-1:0]       w_load_shift;
    logic                    w_next_ser;
    logic [DATA_W-1:0]       w_next_shift;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_push  (en_i),
        .i_pop   (w_pop),
        .i_data  (prl_data_i),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_pre_done  = (r_state == ST_PRE) && (r_cnt == '0);
    assign w_word_done = ((r_state == ST_DATA) && (r_cnt == '0) && !PARITY_EN)
                       || (r_state == ST_PAR);
    // A push landing on the final-bit edge still extends the frame.
    assign w_avail     = ~w_empty | en_i;
    assign w_pop       = w_pre_done | (w_word_done & w_avail);

    // First bit of a freshly popped word and the remainder left to shift
    assign w_load_ser   = MSB_FIRST ? w_fifo_data[DATA_W-1] : w_fifo_data[0];
    assign w_load_shift = MSB_FIRST ? (w_fifo_data << 1) : (w_fifo_data >> 1);
    assign w_next_ser   = MSB_FIRST ? r_shift[DATA_W-1] : r_shift[0];
    assign w_next_shift = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);

    assign ser_data_o = r_ser;
    assign en_o       = r_en;
    assign busy_o     = (r_state != ST_IDLE) || (w_count != '0);
    assign full_o     = w_full;
    assign ovf_o      = r_ovf;

    // Framer FSM: preamble, then words back-to-back, optional parity per word
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_ser   <= 1'b0;
            r_en    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_ovf <= en_i & w_full & ~w_pop;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_state <= ST_PRE;
                        r_en    <= 1'b1;
                        r_ser   <= PREAMBLE_PAT[PREAMBLE-1];
                        r_cnt   <= c_cnt_w'(PREAMBLE - 1);
                    end
                end
                ST_PRE: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_DATA;
                        r_ser   <= w_load_ser;
                        r_shift <= w_load_shift;
                        r_par   <= (^w_fifo_data) ^ PARITY_ODD;
                        r_cnt   <= c_cnt_w'(DATA_W - 1);
                    end else begin
                        r_ser <= PREAMBLE_PAT[r_cnt - 1'b1];
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DATA, ST_PAR: begin
                    if ((r_state == ST_DATA) && (r_cnt != '0)) begin
                        r_ser   <= w_next_ser;
                        r_shift <= w_next_shift;
                        r_cnt   <= r_cnt - 1'b1;
                    end else if ((r_state == ST_DATA) && PARITY_EN) begin
                        r_state <= ST_PAR;
                        r_ser   <= r_par;
                    end else if (w_avail) begin
                        r_state <= ST_DATA;
                        r_ser   <= w_load_ser;
                        r_shift <= w_load_shift;
                        r_par   <= (^w_fifo_data) ^ PARITY_ODD;
                        r_cnt   <= c_cnt_w'(DATA_W - 1);
                    end else begin
                        r_state <= ST_IDLE;
                        r_ser   <= 1'b0;
                        r_en    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ser   <= 1'b0;
                    r_en    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_framed_par_to_ser.sv
`default_nettype none
// ============================================================================
// Module   : tb_framed_par_to_ser
// Brief    : Directed self-checking bench for framed_par_to_ser. Five instances
//            cover default, DEPTH=4, even parity, odd parity and LSB-first.
// Revision : 1.0 - initial release
// ============================================================================
module tb_framed_par_to_ser;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en_v   [5];
    logic [7:0] d_v    [5];
    logic       ser_v  [5];
    logic       eno_v  [5];
    logic       busy_v [5];
    logic       full_v [5];
    logic       ovf_v  [5];

    int checks   = 0;
    int failures = 0;

    // Frame monitor state, cleared through mon_clr
    logic        mon_clr = 1'b0;
    logic [63:0] sh    [5];
    int          nb    [5];
    int          nfr   [5];
    int          novf  [5];
    logic        fseen [5];
    logic        prev  [5];

    always #5 clk = ~clk;

    framed_par_to_ser u_def (
        .clk_i(clk), .rst_i(rst), .en_i(en_v[0]), .prl_data_i(d_v[0]),
        .ser_data_o(ser_v[0]), .en_o(eno_v[0]), .busy_o(busy_v[0]),
        .full_o(full_v[0]), .ovf_o(ovf_v[0]));

    framed_par_to_ser #(.DEPTH(4)) u_d4 (
        .clk_i(clk), .rst_i(rst), .en_i(en_v[1]), .prl_data_i(d_v[1]),
        .ser_data_o(ser_v[1]), .en_o(eno_v[1]), .busy_o(busy_v[1]),
        .full_o(full_v[1]), .ovf_o(ovf_v[1]));

    framed_par_to_ser #(.PARITY_EN(1'b1)) u_pe (
        .clk_i(clk), .rst_i(rst), .en_i(en_v[2]), .prl_data_i(d_v[2]),
        .ser_data_o(ser_v[2]), .en_o(eno_v[2]), .busy_o(busy_v[2]),
        .full_o(full_v[2]), .ovf_o(ovf_v[2]));

    framed_par_to_ser #(.PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_po (
        .clk_i(clk), .rst_i(rst), .en_i(en_v[3]), .prl_data_i(d_v[3]),
        .ser_data_o(ser_v[3]), .en_o(eno_v[3]), .busy_o(busy_v[3]),
        .full_o(full_v[3]), .ovf_o(ovf_v[3]));

    framed_par_to_ser #(.MSB_FIRST(1'b0)) u_lsb (
        .clk_i(clk), .rst_i(rst), .en_i(en_v[4]), .prl_data_i(d_v[4]),
        .ser_data_o(ser_v[4]), .en_o(eno_v[4]), .busy_o(busy_v[4]),
        .full_o(full_v[4]), .ovf_o(ovf_v[4]));

    // Sample every instance on the falling edge and record frame activity
    always @(negedge clk) begin
        for (int k = 0; k < 5; k++) begin
            if (mon_clr) begin
                sh[k]    <= '0;
                nb[k]    <= 0;
                nfr[k]   <= 0;
                novf[k]  <= 0;
                fseen[k] <= 1'b0;
                prev[k]  <= 1'b0;
            end else begin
                if (eno_v[k]) begin
                    sh[k] <= {sh[k][62:0], ser_v[k]};
                    nb[k] <= nb[k] + 1;
                end
                if (eno_v[k] && !prev[k]) nfr[k] <= nfr[k] + 1;
                if (ovf_v[k]) novf[k] <= novf[k] + 1;
                if (full_v[k]) fseen[k] <= 1'b1;
                prev[k] <= eno_v[k];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        #1 mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    // Push n bytes on consecutive edges; first word in the top byte used
    task automatic push_seq(input int k, input logic [63:0] words, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            en_v[k] = 1'b1;
            d_v[k]  = words[8*(n-1-i) +: 8];
        end
        @(negedge clk);
        en_v[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        int n = 0;
        while (busy_v[k] && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 64'(n >= 300), 64'd0);
        repeat (2) @(negedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 5; k++) begin
            en_v[k] = 1'b0;
            d_v[k]  = 8'h00;
        end

        // Reset state
        repeat (2) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("reset_outs_%0d", k),
                64'({ser_v[k], eno_v[k], busy_v[k], full_v[k], ovf_v[k]}), 64'd0);
        end
        rst = 1'b0;
        clr_mon();

        // Default, single word 0xA9: timing of first preamble bit, then frame
        @(negedge clk);
        en_v[0] = 1'b1;
        d_v[0]  = 8'hA9;
        @(negedge clk);
        en_v[0] = 1'b0;
        chk("push_busy_rise", 64'(busy_v[0]), 64'd1);
        chk("push_en_o_still_low", 64'(eno_v[0]), 64'd0);
        @(negedge clk);
        chk("first_pre_bit", 64'({eno_v[0], ser_v[0]}), 64'b11);
        wait_idle(0);
        chk("single_len", 64'(nb[0]), 64'd14);
        chk("single_bits", sh[0] & 64'h3FFF, 64'b101010_10101001);
        chk("single_frames", 64'(nfr[0]), 64'd1);
        chk("single_ovf", 64'(novf[0]), 64'd0);
        chk("single_busy_end", 64'(busy_v[0]), 64'd0);

        // Default, 5-word burst: one preamble, 46 continuous bits
        clr_mon();
        push_seq(0, 64'hBA_A2_E3_AA_BF, 5);
        wait_idle(0);
        chk("burst_len", 64'(nb[0]), 64'd46);
        chk("burst_bits", sh[0] & 64'h3FFF_FFFF_FFFF, {18'd0, 6'b101010, 40'hBA_A2_E3_AA_BF});
        chk("burst_frames", 64'(nfr[0]), 64'd1);
        chk("burst_full", 64'(fseen[0]), 64'd0);

        // DEPTH=4, six consecutive pushes: last two rejected
        clr_mon();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 3) chk("d4_full_after3", 64'(full_v[1]), 64'd0);
            if (i == 4) chk("d4_full_after4", 64'(full_v[1]), 64'd1);
            en_v[1] = 1'b1;
            d_v[1]  = 8'(8'h11 * (i + 1));
        end
        @(negedge clk);
        en_v[1] = 1'b0;
        wait_idle(1);
        chk("d4_len", 64'(nb[1]), 64'd38);
        chk("d4_bits", sh[1] & 64'h3F_FFFF_FFFF, {26'd0, 6'b101010, 32'h11_22_33_44});
        chk("d4_ovf_pulses", 64'(novf[1]), 64'd2);
        chk("d4_frames", 64'(nfr[1]), 64'd1);

        // Even parity on 0xB9
        clr_mon();
        push_seq(2, 64'hB9, 1);
        wait_idle(2);
        chk("par_even_len", 64'(nb[2]), 64'd15);
        chk("par_even_bits", sh[2] & 64'h7FFF, 64'b101010_10111001_1);

        // Odd parity on 0xB9
        push_seq(3, 64'hB9, 1);
        wait_idle(3);
        chk("par_odd_len", 64'(nb[3]), 64'd15);
        chk("par_odd_bits", sh[3] & 64'h7FFF, 64'b101010_10111001_0);

        // LSB first on 0xA9
        push_seq(4, 64'hA9, 1);
        wait_idle(4);
        chk("lsb_len", 64'(nb[4]), 64'd14);
        chk("lsb_bits", sh[4] & 64'h3FFF, 64'b101010_10010101);

        // Reset on the third data bit of a 3-word burst
        clr_mon();
        push_seq(0, 64'h81_42_24, 3);
        repeat (7) @(negedge clk);
        chk("pre_reset_bit3", 64'({eno_v[0], ser_v[0]}), 64'b10);
        #2;
        rst     = 1'b1;
        en_v[0] = 1'b1;
        d_v[0]  = 8'hFF;
        #1;
        chk("async_reset_outs",
            64'({ser_v[0], eno_v[0], busy_v[0], full_v[0], ovf_v[0]}), 64'd0);
        repeat (3) @(negedge clk);
        rst     = 1'b0;
        en_v[0] = 1'b0;
        clr_mon();
        repeat (30) @(negedge clk);
        #1;
        chk("post_reset_frames", 64'(nfr[0]), 64'd0);
        chk("post_reset_busy", 64'(busy_v[0]), 64'd0);

        clr_mon();
        push_seq(0, 64'h5A, 1);
        wait_idle(0);
        chk("post_reset_len", 64'(nb[0]), 64'd14);
        chk("post_reset_bits", sh[0] & 64'h3FFF, 64'b101010_01011010);
        chk("post_reset_nfr", 64'(nfr[0]), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
